event_ring_sequencer: RTL and testbench
=======================================

Name: event_ring_sequencer

Overview:
- Synthesizable, parametrised ring of NPROC event-driven processes that pass a single wake token round-robin.
- Each process waits for its wake, counts a per-process programmable delay, fires, then wakes the next process.
- Completes after ROUNDS full rotations. External per-process wake injection is supported; wakes that reach a process not currently waiting are dropped and counted, which matches SV named-event semantics.
- Used as a scheduler/ordering stimulus block in the dynamic-scheduler regression designs.

Parameters:
- NPROC, 3, number of processes in the ring (>=2).
- DELAY_W, 4, width of each per-process delay field.
- ROUNDS, 2, number of full rotations before done (>=1).
- DROP_W, 8, width of the saturating dropped-wake counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle start pulse; honoured only in IDLE or DONE.
- delay_cfg  in  NPROC*DELAY_W  per-process delay d_i; field i = bits [i*DELAY_W +: DELAY_W]; sampled when process i accepts a wake.
- ext_wake  in  NPROC  external wake pulse per process.
- fire  out  NPROC  one-hot-per-process fire strobe (one cycle each).
- fire_any  out  1  OR of fire.
- fire_id  out  max(1,$clog2(NPROC))  index of the lowest set fire bit; 0 when none.
- round_cnt  out  $clog2(ROUNDS+1)  number of fires from process NPROC-1 since start.
- drop_cnt  out  DROP_W  dropped wakes, saturating at all-ones.
- busy  out  1  global state is RUN.
- done  out  1  global state is DONE.

Behaviour:
- Reset, async on rst=1, takes effect immediately mid-operation: global IDLE; every process IDLE; fire=0, fire_any=0, fire_id=0, round_cnt=0, drop_cnt=0, busy=0, done=0. No fire strobes occur in the first cycle after rst deassertion.
- Global FSM:
  - IDLE -start-> RUN.
  - RUN -final fire-> DONE.
  - DONE -start-> RUN.
  - start during RUN is ignored.
- On start (sampled at end of cycle t):
  - All processes go to WAIT.
  - round_cnt and drop_cnt clear to 0; done clears.
  - Process 0 receives a wake at the same edge, so it behaves as if woken at end of cycle t.
- Per-process FSM states: IDLE, WAIT, DELAY, FIRE.
  - Wake to process i = ring_wake_i OR ext_wake[i]. ring_wake_i = fire[(i-1) mod NPROC] in the same cycle, suppressed on the final fire.
  - WAIT + wake sampled at end of cycle t, with d = delay_cfg field i captured at that edge: DELAY for cycles t+1..t+d, then FIRE in cycle t+d+1. If d=0, FIRE is in t+1.
  - FIRE lasts exactly 1 cycle: fire[i]=1, then return to WAIT.
  - Per-hop latency = d_i+1 cycles. One full rotation = sum over i of (d_i+1).
- Drops (RUN only):
  - A wake sampled while process i is in DELAY or FIRE is discarded and drop_cnt increments by 1.
  - Several drops in one cycle add their count; the counter saturates and never wraps.
  - Ring wake and ext_wake arriving together at a WAIT process make one wake and no drop.
  - In global IDLE or DONE, ext_wake is ignored and not counted.
- Multiple tokens may circulate after injection. Each fire of process NPROC-1 increments round_cnt, whatever the token origin.
- Final fire: the fire of process NPROC-1 that brings round_cnt to ROUNDS.
  - fire is still asserted that cycle.
  - Next cycle: global DONE, done=1, busy=0, all processes IDLE; any token still in DELAY is discarded.
  - done holds until start or rst.
- Outputs fire, fire_any and fire_id are registered-state decodes (FIRE state); no combinational path from inputs.

Test Plan:
1. NPROC=3, ROUNDS=2, all d=1, start in cycle 0 -> fire[0] in cycles 2 and 8, fire[1] in 4 and 10, fire[2] in 6 and 12; round_cnt 1 at 7 and 2 at 13; done=1 from cycle 13; drop_cnt=0.
2. All d=0, start in cycle 0 -> fires in cycles 1,2,3,4,5,6 with fire_id 0,1,2,0,1,2; done from cycle 7.
3. d={3,1,1}, ext_wake[0] pulsed in cycle 2, while process 0 is in DELAY -> drop_cnt=1; fire timing unchanged (fire[0] in cycle 4).
4. All d=1; ext_wake[1] in cycle 2, the same cycle as the ring wake from fire[0] -> single wake, drop_cnt=0, fire[1] in cycle 4 only.
5. All d=1; ext_wake[2] in cycle 1 -> second token, fire[2] in cycle 3; round_cnt=1 at cycle 4; done early from cycle 7.
6. rst asserted mid-run in cycle 5 (async, between edges) -> all outputs 0 immediately; start after release restarts and repeats the scenario 1 timing relative to the new start.

Source files
------------

// File: rtl/event_ring_sequencer.sv
// Ring of NPROC event-driven processes passing a wake token round-robin.
// Each process waits for a wake, counts its programmable delay, fires for
// one cycle and wakes its successor. The run ends after ROUNDS fires of the
// last process. Wakes reaching a process that is not waiting are dropped
// and counted.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       start pulse, honoured in IDLE or DONE
//   delay_cfg   per-process delay, field i = [i*DELAY_W +: DELAY_W]
//   ext_wake    external wake pulse per process
//   fire        per-process fire strobe (decode of FIRE state)
//   fire_any    OR of fire
//   fire_id     lowest set fire index, 0 when none
//   round_cnt   fires of process NPROC-1 since start
//   drop_cnt    saturating dropped-wake counter
//   busy, done  global RUN / DONE state
module event_ring_sequencer #(
  parameter int unsigned NPROC   = 3,
  parameter int unsigned DELAY_W = 4,
  parameter int unsigned ROUNDS  = 2,
  parameter int unsigned DROP_W  = 8,
  localparam int unsigned FID_W  = (NPROC > 1) ? $clog2(NPROC) : 1,
  localparam int unsigned RND_W  = $clog2(ROUNDS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NPROC*DELAY_W-1:0]   delay_cfg,
  input  logic [NPROC-1:0]           ext_wake,
  output logic [NPROC-1:0]           fire,
  output logic                       fire_any,
  output logic [FID_W-1:0]           fire_id,
  output logic [RND_W-1:0]           round_cnt,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} gstate_e;
  typedef enum logic [1:0] {P_IDLE, P_WAIT, P_DELAY, P_FIRE} pstate_e;

  gstate_e              gstate_q, gstate_d;
  pstate_e              pstate_q [NPROC];
  pstate_e              pstate_d [NPROC];
  logic [DELAY_W-1:0]   cnt_q [NPROC];
  logic [DELAY_W-1:0]   cnt_d [NPROC];
  logic [RND_W-1:0]     round_cnt_q, round_cnt_d;
  logic [DROP_W-1:0]    drop_cnt_q, drop_cnt_d;

  logic [NPROC-1:0]     fire_c;
  logic [NPROC-1:0]     ring_c;
  logic [NPROC-1:0]     wake_c;
  logic [NPROC-1:0]     drop_c;
  logic [FID_W-1:0]     fire_id_c;
  logic                 final_fire_c;

  // Fire decode from registered process state; lowest index wins for fire_id.
  always_comb begin
    fire_c    = '0;
    fire_id_c = '0;
    for (int i = 0; i < NPROC; i++) begin
      fire_c[i] = (pstate_q[i] == P_FIRE);
    end
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (fire_c[i]) fire_id_c = FID_W'(i);
    end
  end

  // Process i is ring-woken by its predecessor, process 0 by process NPROC-1.
  assign ring_c       = {fire_c[NPROC-2:0], fire_c[NPROC-1]};
  assign final_fire_c = (gstate_q == G_RUN) && fire_c[NPROC-1] &&
                        (round_cnt_q == RND_W'(ROUNDS - 1));

  // Global and per-process next state.
  always_comb begin
    gstate_d    = gstate_q;
    round_cnt_d = round_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    wake_c      = '0;
    drop_c      = '0;
    for (int i = 0; i < NPROC; i++) begin
      pstate_d[i] = pstate_q[i];
      cnt_d[i]    = cnt_q[i];
    end

    case (gstate_q)
      G_RUN: begin
        // The final fire does not pass the token on.
        wake_c = ext_wake | (ring_c & {NPROC{~final_fire_c}});
        for (int i = 0; i < NPROC; i++) begin
          case (pstate_q[i])
            P_WAIT: begin
              if (wake_c[i]) begin
                cnt_d[i]    = delay_cfg[i*DELAY_W +: DELAY_W];
                pstate_d[i] = (delay_cfg[i*DELAY_W +: DELAY_W] == '0) ? P_FIRE : P_DELAY;
              end
            end
            P_DELAY: begin
              drop_c[i] = wake_c[i];
              if (cnt_q[i] == DELAY_W'(1)) begin
                pstate_d[i] = P_FIRE;
              end else begin
                cnt_d[i] = cnt_q[i] - DELAY_W'(1);
              end
            end
            P_FIRE: begin
              drop_c[i]   = wake_c[i];
              pstate_d[i] = P_WAIT;
            end
            default: ;
          endcase
        end

        if (fire_c[NPROC-1]) round_cnt_d = round_cnt_q + RND_W'(1);

        // Saturating accumulate of this cycle's drops.
        for (int i = 0; i < NPROC; i++) begin
          if (drop_c[i] && (drop_cnt_d != '1)) drop_cnt_d = drop_cnt_d + DROP_W'(1);
        end

        if (final_fire_c) begin
          gstate_d = G_DONE;
          for (int i = 0; i < NPROC; i++) begin
            pstate_d[i] = P_IDLE;
            cnt_d[i]    = '0;
          end
        end
      end

      default: begin
        if (start) begin
          gstate_d    = G_RUN;
          round_cnt_d = '0;
          drop_cnt_d  = '0;
          for (int i = 0; i < NPROC; i++) begin
            pstate_d[i] = P_WAIT;
            cnt_d[i]    = '0;
          end
          // Process 0 takes its wake on the start edge itself.
          cnt_d[0]    = delay_cfg[DELAY_W-1:0];
          pstate_d[0] = (delay_cfg[DELAY_W-1:0] == '0) ? P_FIRE : P_DELAY;
        end
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gstate_q    <= G_IDLE;
      round_cnt_q <= '0;
      drop_cnt_q  <= '0;
      for (int i = 0; i < NPROC; i++) begin
        pstate_q[i] <= P_IDLE;
        cnt_q[i]    <= '0;
      end
    end else begin
      gstate_q    <= gstate_d;
      round_cnt_q <= round_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      for (int i = 0; i < NPROC; i++) begin
        pstate_q[i] <= pstate_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign fire      = fire_c;
  assign fire_any  = |fire_c;
  assign fire_id   = fire_id_c;
  assign round_cnt = round_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (gstate_q == G_RUN);
  assign done      = (gstate_q == G_DONE);

endmodule

// File: tb/tb_event_ring_sequencer.sv
// Directed bench for event_ring_sequencer (NPROC=3, DELAY_W=4, ROUNDS=2).
// Cycle c of a scenario is the interval after the c-th edge; start is
// driven in cycle 0 and outputs are sampled 1 ns after each rising edge.
module tb_event_ring_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] delay_cfg;
  logic [2:0]  ext_wake;
  logic [2:0]  fire;
  logic        fire_any;
  logic [1:0]  fire_id;
  logic [1:0]  round_cnt;
  logic [7:0]  drop_cnt;
  logic        busy;
  logic        done;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [2:0]  exp_fire [0:23];

  event_ring_sequencer #(
    .NPROC(3), .DELAY_W(4), .ROUNDS(2), .DROP_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .delay_cfg(delay_cfg),
    .ext_wake(ext_wake), .fire(fire), .fire_any(fire_any),
    .fire_id(fire_id), .round_cnt(round_cnt), .drop_cnt(drop_cnt),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 24; k++) exp_fire[k] = 3'b000;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " fire"},      32'(fire), 0);
    check_eq({tag, " fire_any"},  32'(fire_any), 0);
    check_eq({tag, " fire_id"},   32'(fire_id), 0);
    check_eq({tag, " round_cnt"}, 32'(round_cnt), 0);
    check_eq({tag, " drop_cnt"},  32'(drop_cnt), 0);
    check_eq({tag, " busy"},      32'(busy), 0);
    check_eq({tag, " done"},      32'(done), 0);
  endtask

  // Runs ncyc cycles from the current cycle, checking against exp_fire.
  task automatic run_scn(input string name, input logic [11:0] dcfg,
                         input int ext_cyc, input logic [2:0] ext_mask,
                         input int ncyc, input int done_from,
                         input bit prev_done, input bit do_final,
                         input int unsigned exp_drop);
    int unsigned exp_rnd;
    int unsigned exp_id;
    delay_cfg = dcfg;
    for (int c = 0; c < ncyc; c++) begin
      start    = (c == 0);
      ext_wake = (c == ext_cyc) ? ext_mask : 3'b000;
      exp_id   = exp_fire[c][0] ? 0 : exp_fire[c][1] ? 1 : exp_fire[c][2] ? 2 : 0;
      check_eq($sformatf("%s c%0d fire", name, c),     32'(fire), 32'(exp_fire[c]));
      check_eq($sformatf("%s c%0d fire_any", name, c), 32'(fire_any), 32'(|exp_fire[c]));
      check_eq($sformatf("%s c%0d fire_id", name, c),  32'(fire_id), exp_id);
      if (c == 0) begin
        check_eq($sformatf("%s c0 done", name), 32'(done), 32'(prev_done));
      end else begin
        exp_rnd = 0;
        for (int k = 1; k < c; k++) if (exp_fire[k][2]) exp_rnd++;
        check_eq($sformatf("%s c%0d round_cnt", name, c), 32'(round_cnt), exp_rnd);
        check_eq($sformatf("%s c%0d done", name, c), 32'(done), 32'(c >= done_from));
        check_eq($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(c < done_from));
      end
      if (c < ncyc - 1 || do_final) begin
        @(posedge clk);
        #1;
      end
    end
    start    = 1'b0;
    ext_wake = 3'b000;
    if (do_final) begin
      check_eq({name, " final drop_cnt"},  32'(drop_cnt), exp_drop);
      check_eq({name, " final round_cnt"}, 32'(round_cnt), 2);
      check_eq({name, " final done"},      32'(done), 1);
    end
  endtask

  task automatic set_s1();
    clear_exp();
    exp_fire[2]  = 3'b001; exp_fire[4]  = 3'b010; exp_fire[6]  = 3'b100;
    exp_fire[8]  = 3'b001; exp_fire[10] = 3'b010; exp_fire[12] = 3'b100;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    delay_cfg = '0;
    ext_wake  = '0;
    #2;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("post-reset");

    // 1: all delays 1.
    set_s1();
    run_scn("s1", 12'h111, -1, 3'b000, 16, 13, 1'b0, 1'b1, 0);

    // 2: all delays 0, restarted directly from DONE.
    clear_exp();
    exp_fire[1] = 3'b001; exp_fire[2] = 3'b010; exp_fire[3] = 3'b100;
    exp_fire[4] = 3'b001; exp_fire[5] = 3'b010; exp_fire[6] = 3'b100;
    run_scn("s2", 12'h000, -1, 3'b000, 10, 7, 1'b1, 1'b1, 0);

    // 3: d0=3, d1=d2=1; external wake to process 0 while it is delaying.
    clear_exp();
    exp_fire[4]  = 3'b001; exp_fire[6]  = 3'b010; exp_fire[8]  = 3'b100;
    exp_fire[12] = 3'b001; exp_fire[14] = 3'b010; exp_fire[16] = 3'b100;
    run_scn("s3", 12'h113, 2, 3'b001, 20, 17, 1'b1, 1'b1, 1);

    // 4: external wake coincident with the ring wake merges into one.
    set_s1();
    run_scn("s4", 12'h111, 2, 3'b010, 16, 13, 1'b1, 1'b1, 0);

    // 5: second token injected at process 2 ends the run early.
    clear_exp();
    exp_fire[2] = 3'b001; exp_fire[3] = 3'b100; exp_fire[4] = 3'b010;
    exp_fire[5] = 3'b001; exp_fire[6] = 3'b100;
    run_scn("s5", 12'h111, 1, 3'b100, 10, 7, 1'b1, 1'b1, 0);

    // 6: asynchronous reset mid-run, then a clean restart.
    set_s1();
    run_scn("s6a", 12'h111, -1, 3'b000, 6, 99, 1'b1, 1'b0, 0);
    check_eq("s6 busy before rst", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("s6 async rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("s6 after release");
    set_s1();
    run_scn("s6b", 12'h111, -1, 3'b000, 16, 13, 1'b0, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
